lsu_mem_initiator: RTL
======================

// Module: lsu_mem_initiator
// PURPOSE
//  Load/store initiator for the RV32IM core. Takes one pipeline memory request at a time and drives the word-addressed data RAM port:
//  read enable, write enable, word address, write data; RAM read data returns one cycle later.
//  Handles byte/half/word lane selection, sign/zero extension, and read-modify-write for SB/SH, since the RAM has no byte enables.
//  Sits between the execute/memory stage and the data RAM.
// PARAMETERS
//  ADDR_WIDTH      32  byte-address width of req_addr
//  MEM_ADDR_WIDTH  10  word-address width of mem_addr (RAM depth = 2**MEM_ADDR_WIDTH words)
//  DATA_WIDTH      32  data width; only 32 is supported
// PORTS
//  clk          in   1               clock, rising edge
//  rst          in   1               synchronous reset, active-high
//  req_valid    in   1               request present
//  req_ready    out  1               request can be accepted (IDLE only)
//  req_we       in   1               1 = store, 0 = load
//  req_funct3   in   3               RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr     in   ADDR_WIDTH      byte address
//  req_wdata    in   DATA_WIDTH      store data; low bytes used for SB/SH
//  resp_valid   out  1               one-cycle pulse: request complete; no backpressure
//  resp_rdata   out  DATA_WIDTH      extended load data; 0 for stores/errors
//  resp_err     out  1               illegal funct3 or misaligned (macro on)
//  mem_addr     out  MEM_ADDR_WIDTH  word address = req_addr[MEM_ADDR_WIDTH+1:2]
//  mem_wdata    out  DATA_WIDTH      word to write
//  mem_read_en  out  1               RAM read strobe
//  mem_write_en out  1               RAM write strobe
//  mem_rdata    in   DATA_WIDTH      RAM registered read data, valid the cycle after mem_read_en
// BEHAVIOUR
//  - All outputs are registered. Reset: state=IDLE, req_ready=1, all other outputs 0.
//  - Accept when req_valid && req_ready. Request fields are latched at accept. Acceptance cycle = cycle 0.
//  - FSM states: IDLE, RD_ISSUE, RD_CAPTURE, WR, DONE.
//    Load:    IDLE->RD_ISSUE(c1, mem_read_en=1)->RD_CAPTURE(c2, extract+extend)->DONE(c3, resp_valid=1)->IDLE
//    SW:      IDLE->WR(c1, mem_write_en=1, mem_wdata=req_wdata)->DONE(c2)->IDLE
//    SB/SH:   IDLE->RD_ISSUE(c1)->RD_CAPTURE(c2, merge lane)->WR(c3)->DONE(c4)->IDLE
//    Error:   IDLE->DONE(c1, resp_err=1); no mem strobe is ever asserted
//  - mem_read_en and mem_write_en are never high together. Each is high for exactly one cycle per access.
//  - Lane select: byte lane = addr[1:0]; half lane = addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
//  - Merge: only the addressed byte/half of the read word is replaced with req_wdata[7:0]/[15:0]; other bytes are preserved.
//  - Illegal funct3: 011, 110, 111, or a store with funct3[2]=1.
//  - Address bits above MEM_ADDR_WIDTH+1 are ignored; the address wraps modulo RAM size.
//  - req_ready=0 from cycle 1 through DONE, and returns to 1 the cycle after DONE. No request overlap.
//  - Reset mid-operation: the in-flight access is dropped and no resp_valid is produced.
//    Any mem strobe not yet issued is suppressed. req_ready=1 the cycle after reset.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]!=0, or LW/SW with addr[1:0]!=0, take the Error path (resp_err=1, no access).
//  Not defined: misaligned low bits are forced to natural alignment (addr[0]=0 for H, addr[1:0]=0 for W). The access proceeds, resp_err=0.
// TESTING
//  RAM model: 1-cycle registered read, preloaded to 0.
//  1. SW 0x10 0xDEADBEEF; LW 0x10 -> write in c1, resp c2; LW resp_valid in c3, rdata=0xDEADBEEF, err=0
//  2. Word 0x10=0xDEADBEEF: LB 0x13->0xFFFFFFDE; LBU 0x13->0x000000DE; LH 0x12->0xFFFFDEAD; LHU 0x10->0x0000BEEF
//  3. SB 0x11 wdata 0x123456AA -> one read c1, one write c3 with mem_wdata=0xDEADAAEF, resp c4; LW 0x10->0xDEADAAEF
//  4. LW 0x12 -> macro on: resp_err=1 in c1, no strobes; macro off: reads word 0x10, rdata=0xDEADAAEF, err=0
//  5. SH 0x14 with rst high in c2 -> no mem_write_en and no resp_valid; req_ready=1 next cycle; word 0x14 unchanged
//  6. funct3=011 load, funct3=100 store -> resp_err=1 in c1, resp_rdata=0, no strobes; back-to-back req_valid accepted cycle after DONE

Source files
------------

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: one request at a time onto a word-addressed RAM without byte enables.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses into errors instead of forcing alignment.
module lsu_mem_initiator #(
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [2:0]                req_funct3,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      resp_valid,
  output logic [DATA_WIDTH-1:0]     resp_rdata,
  output logic                      resp_err,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic                      mem_read_en,
  output logic                      mem_write_en,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic [2:0]                dbg_state
);

  // Handshake: a request transfers on a rising edge with req_valid && req_ready;
  // resp_valid is a single-cycle pulse with no backpressure.
  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_CAPTURE, WR, DONE} state_t;

  state_t                    state_q;
  logic                      req_ready_q, resp_valid_q, resp_err_q;
  logic                      mem_read_en_q, mem_write_en_q;
  logic [DATA_WIDTH-1:0]     resp_rdata_q, mem_wdata_q;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q;
  logic                      we_q;
  logic [2:0]                f3_q;
  logic [1:0]                off_q;
  logic [15:0]               wdata_q;

  logic [1:0]                off_d;
  logic                      illegal_d, misalign_d, err_d;
  logic [DATA_WIDTH-1:0]     shifted, load_ext, merged;
  logic                      unused_addr_bits;

  assign unused_addr_bits = ^req_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2];

  always_comb begin
    off_d      = 2'b00;
    misalign_d = 1'b0;
    case (req_funct3[1:0])
      2'b00: off_d = req_addr[1:0];
      2'b01: begin
        off_d      = {req_addr[1], 1'b0};
        misalign_d = req_addr[0];
      end
      default: misalign_d = (req_addr[1:0] != 2'b00);
    endcase
    illegal_d = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                (req_we && req_funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    err_d = illegal_d || misalign_d;
`else
    err_d = illegal_d;
`endif
  end

  // Lane extract for loads and lane merge for SB/SH, both off the returning RAM word.
  always_comb begin
    shifted  = mem_rdata >> {off_q, 3'b000};
    load_ext = shifted;
    merged   = mem_rdata;
    case (f3_q[1:0])
      2'b00: begin
        load_ext = {{(DATA_WIDTH-8){~f3_q[2] & shifted[7]}}, shifted[7:0]};
        merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_ext = {{(DATA_WIDTH-16){~f3_q[2] & shifted[15]}}, shifted[15:0]};
        merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      req_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_err_q     <= 1'b0;
      resp_rdata_q   <= '0;
      mem_read_en_q  <= 1'b0;
      mem_write_en_q <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      we_q           <= 1'b0;
      f3_q           <= 3'b000;
      off_q          <= 2'b00;
      wdata_q        <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          we_q        <= req_we;
          f3_q        <= req_funct3;
          off_q       <= off_d;
          wdata_q     <= req_wdata[15:0];
          mem_addr_q  <= req_addr[MEM_ADDR_WIDTH+1:2];
          req_ready_q <= 1'b0;
          if (err_d) begin
            state_q      <= DONE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end else if (req_we && req_funct3[1:0] == 2'b10) begin
            state_q        <= WR;
            mem_write_en_q <= 1'b1;
            mem_wdata_q    <= req_wdata;
          end else begin
            state_q       <= RD_ISSUE;
            mem_read_en_q <= 1'b1;
          end
        end
        RD_ISSUE: begin
          mem_read_en_q <= 1'b0;
          state_q       <= RD_CAPTURE;
        end
        RD_CAPTURE: begin
          if (we_q) begin
            mem_wdata_q    <= merged;
            mem_write_en_q <= 1'b1;
            state_q        <= WR;
          end else begin
            resp_rdata_q <= load_ext;
            resp_valid_q <= 1'b1;
            state_q      <= DONE;
          end
        end
        WR: begin
          mem_write_en_q <= 1'b0;
          resp_valid_q   <= 1'b1;
          resp_rdata_q   <= '0;
          state_q        <= DONE;
        end
        DONE: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_err     = resp_err_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_read_en  = mem_read_en_q;
  assign mem_write_en = mem_write_en_q;
  assign dbg_state    = state_q;

endmodule
